// File: rtl/modacc249857s.sv
// Modular accumulator: sums len signed terms, reducing mod+-249857 each step.
// Optional MODACC249857S_RANGECHK_EN zeroes out-of-range terms and flags err.
module modacc249857s #(
    parameter int LENW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LENW-1:0]        len,
    input  logic                   inV,
    input  logic signed [17:0]     inZ,
    output logic                   busy,
    output logic                   outV,
    output logic signed [17:0]     outZ,
    output logic                   err
);

    localparam logic signed [18:0] MOD  = 19'sd249857;
    localparam logic signed [18:0] HALF = 19'sd124928;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LENW-1:0]       r_cnt;
    logic signed [17:0]    r_acc;
    logic signed [17:0]    r_outZ;
    logic signed [17:0]    w_term;
    logic signed [18:0]    w_sum;
    logic signed [18:0]    w_red19;
    logic signed [17:0]    w_red;
    logic                  w_load;
    logic                  w_take;
    logic                  w_last;

    assign w_load = (r_state != ACC) && start;
    assign w_take = (r_state == ACC) && inV;
    assign w_last = w_take && (r_cnt == LENW'(1));

`ifdef MODACC249857S_RANGECHK_EN
    logic w_oor;
    logic r_err;

    assign w_oor  = (inZ > 18'sd124928) || (inZ < -18'sd124928);
    assign w_term = w_oor ? 18'sd0 : inZ;
    assign err    = r_err;

    // Cleared only when a new run is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_take && w_oor) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_term = inZ;
    assign err    = 1'b0;
`endif

    assign w_sum = {r_acc[17], r_acc} + {w_term[17], w_term};

    always_comb begin
        w_red19 = w_sum;
        if (w_sum > HALF) begin
            w_red19 = w_sum - MOD;
        end else if (w_sum < -HALF) begin
            w_red19 = w_sum + MOD;
        end
    end

    assign w_red = w_red19[17:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        outV   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                outV = 1'b1;
                if (start) begin
                    w_next = (len != '0) ? ACC : DONE;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Result register is loaded on entry to DONE and held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_outZ <= '0;
        end else if (w_load) begin
            r_cnt <= len;
            r_acc <= '0;
            if (len == '0) begin
                r_outZ <= '0;
            end
        end else if (w_take) begin
            r_acc <= w_red;
            r_cnt <= r_cnt - LENW'(1);
            if (w_last) begin
                r_outZ <= w_red;
            end
        end
    end

    assign outZ = r_outZ;

endmodule
